// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: loader, fetch port, data port and memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
    parameter int AW = 8
);
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          ld_ready;
    logic          core_run;

    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          err_misalign;

    modport slave (
        input  ld_valid, ld_data, ld_done,
        output ld_ready, core_run,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output err_misalign
    );

    modport master (
        output ld_valid, ld_data, ld_done,
        input  ld_ready, core_run,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  err_misalign
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: boot loader fills memory in LOAD, then in RUN
// the core's fetch and data ports share the memory with data priority and a
// starvation guard that forces a fetch grant after two consecutive denials.
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int LOAD_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic {LOAD, RUN} state_t;

    localparam logic [AW-1:0] LOAD_LAST = AW'(LOAD_MAX);

    state_t        state, state_nx;
    logic [AW-1:0] ld_ptr, ld_ptr_nx;
    logic [1:0]    starve, starve_nx;
    logic          grant_i, grant_d;
    logic          pend_i, pend_d;
    logic          err_q;
    logic          misalign;
    logic [31:0]   if_rdata_q, d_rdata_q;

    // State, load pointer and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            ld_ptr <= '0;
            starve <= '0;
        end else begin
            state  <= state_nx;
            ld_ptr <= ld_ptr_nx;
            starve <= starve_nx;
        end
    end

    // Next state, arbitration and memory request steering.
    always_comb begin
        state_nx      = state;
        ld_ptr_nx     = ld_ptr;
        starve_nx     = starve;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.core_run  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            LOAD: begin
                // Reset lands in LOAD, so gate with rst_n to keep the loader
                // stalled and the memory quiet while reset is held.
                bus.ld_ready = rst_n;
                if (rst_n && bus.ld_valid) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = ld_ptr;
                    bus.mem_wdata = bus.ld_data;
                    ld_ptr_nx     = ld_ptr + 1'b1;
                    if (ld_ptr == LOAD_LAST) state_nx = RUN;
                end
                if (bus.ld_done) state_nx = RUN;
            end
            RUN: begin
                bus.core_run = 1'b1;
                grant_i = bus.if_req && (!bus.d_req || starve == 2'd2);
                grant_d = bus.d_req && !grant_i;
                starve_nx = (bus.if_req && !grant_i) ? starve + 2'd1 : 2'd0;
                if (grant_i) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = bus.if_addr[AW+1:2];
                end else if (grant_d) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.d_we;
                    bus.mem_addr  = bus.d_addr[AW+1:2];
                    bus.mem_wdata = bus.d_wdata;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    assign misalign = (grant_i && bus.if_addr[1:0] != 2'b00) ||
                      (grant_d && bus.d_addr[1:0]  != 2'b00);

    // Read-return tracking, held read data and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_i     <= 1'b0;
            pend_d     <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            pend_i <= grant_i;
            pend_d <= grant_d && !bus.d_we;
            if (misalign) err_q <= 1'b1;
            if (pend_i) if_rdata_q <= bus.mem_rdata;
            if (pend_d) d_rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt       = grant_i;
    assign bus.d_gnt        = grant_d;
    assign bus.if_rvalid    = pend_i;
    assign bus.d_rvalid     = pend_d;
    assign bus.if_rdata     = pend_i ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata      = pend_d ? bus.mem_rdata : d_rdata_q;
    assign bus.err_misalign = err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:AW+2], bus.d_addr[31:AW+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x32 memory attached.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mem_arbiter_if #(.AW(8)) b ();

    mem_arbiter #(.AW(8), .LOAD_MAX(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, one-cycle read latency.
    logic [31:0] mem_model [256];
    logic [31:0] rd_q = '0;
    int unsigned wr_cnt = 0;
    assign b.mem_rdata = rd_q;

    always @(posedge clk) begin
        if (b.mem_en) begin
            if (b.mem_we) begin
                mem_model[b.mem_addr] <= b.mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_q <= mem_model[b.mem_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned wr_base;

    initial begin
        b.ld_valid = 0; b.ld_data = '0; b.ld_done = 0;
        b.if_req = 0; b.if_addr = '0;
        b.d_req = 0; b.d_we = 0; b.d_addr = '0; b.d_wdata = '0;

        // Reset values.
        #2;
        check_eq("rst_ld_ready", 32'(b.ld_ready), 0);
        check_eq("rst_core_run", 32'(b.core_run), 0);
        check_eq("rst_mem_en", 32'(b.mem_en), 0);
        check_eq("rst_gnt", 32'({b.if_gnt, b.d_gnt}), 0);
        check_eq("rst_rvalid", 32'({b.if_rvalid, b.d_rvalid}), 0);
        check_eq("rst_if_rdata", b.if_rdata, 0);
        check_eq("rst_d_rdata", b.d_rdata, 0);
        check_eq("rst_err", 32'(b.err_misalign), 0);
        step(); step();
        rst_n = 1;
        #1;
        check_eq("load_ld_ready", 32'(b.ld_ready), 1);

        // Load 38 words; ld_done accompanies the last one.
        for (int i = 0; i < 38; i++) begin
            b.ld_valid = 1;
            b.ld_data  = 32'hA000_0000 + 32'(i);
            b.ld_done  = (i == 37);
            #1;
            check_eq("load_addr", 32'(b.mem_addr), 32'(i));
            check_eq("load_we", 32'({b.mem_en, b.mem_we, b.core_run}), 32'b110);
            step();
        end
        b.ld_valid = 0; b.ld_done = 0;
        #1;
        check_eq("run_core_run", 32'(b.core_run), 1);
        check_eq("run_ld_ready", 32'(b.ld_ready), 0);
        for (int i = 0; i < 38; i++)
            check_eq("load_content", mem_model[i], 32'hA000_0000 + 32'(i));

        // Fetch read at byte 0x8.
        b.if_req = 1; b.if_addr = 32'h8;
        #1;
        check_eq("fetch_gnt", 32'({b.if_gnt, b.d_gnt}), 32'b10);
        check_eq("fetch_addr", 32'(b.mem_addr), 2);
        check_eq("fetch_en_we", 32'({b.mem_en, b.mem_we}), 32'b10);
        step();
        b.if_req = 0;
        #1;
        check_eq("fetch_rvalid", 32'({b.if_rvalid, b.d_rvalid}), 32'b10);
        check_eq("fetch_rdata", b.if_rdata, 32'hA000_0002);
        step();
        check_eq("fetch_rvalid_low", 32'(b.if_rvalid), 0);
        check_eq("fetch_rdata_hold", b.if_rdata, 32'hA000_0002);

        // Loader ignored in RUN; idle memory port.
        b.ld_valid = 1; b.ld_done = 1;
        #1;
        check_eq("run_ld_ignored", 32'({b.mem_en, b.mem_we, b.ld_ready}), 0);
        step();
        b.ld_valid = 0; b.ld_done = 0;

        // Contention for 4 cycles: D, D, I, D.
        b.if_req = 1; b.if_addr = 32'h10;
        b.d_req = 1; b.d_we = 0; b.d_addr = 32'h14;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("arb_gnt", 32'({b.if_gnt, b.d_gnt}), (k == 2) ? 32'b10 : 32'b01);
            check_eq("arb_addr", 32'(b.mem_addr), (k == 2) ? 32'd4 : 32'd5);
            step();
            if (k == 2) begin
                check_eq("arb_rvalid_i", 32'({b.if_rvalid, b.d_rvalid}), 32'b10);
                check_eq("arb_rdata_i", b.if_rdata, 32'hA000_0004);
            end else begin
                check_eq("arb_rvalid_d", 32'({b.if_rvalid, b.d_rvalid}), 32'b01);
                check_eq("arb_rdata_d", b.d_rdata, 32'hA000_0005);
            end
        end
        b.if_req = 0; b.d_req = 0;

        // Misaligned write with address wrap.
        b.d_req = 1; b.d_we = 1; b.d_addr = 32'h402; b.d_wdata = 32'h6;
        #1;
        check_eq("wr_gnt", 32'(b.d_gnt), 1);
        check_eq("wr_addr", 32'(b.mem_addr), 0);
        check_eq("wr_we", 32'({b.mem_en, b.mem_we}), 32'b11);
        check_eq("wr_wdata", b.mem_wdata, 32'h6);
        check_eq("wr_err_before", 32'(b.err_misalign), 0);
        step();
        b.d_req = 0; b.d_we = 0;
        #1;
        check_eq("wr_err_set", 32'(b.err_misalign), 1);
        check_eq("wr_no_rvalid", 32'(b.d_rvalid), 0);
        b.d_req = 1; b.d_addr = 32'h0;
        step();
        b.d_req = 0;
        #1;
        check_eq("rd_back_rvalid", 32'(b.d_rvalid), 1);
        check_eq("rd_back_data", b.d_rdata, 32'h6);
        check_eq("err_sticky", 32'(b.err_misalign), 1);

        // Reset during a pending fetch read.
        b.if_req = 1; b.if_addr = 32'h4;
        step();
        b.if_req = 0;
        rst_n = 0;
        #1;
        check_eq("rst_mid_rvalid", 32'(b.if_rvalid), 0);
        check_eq("rst_mid_rdata", b.if_rdata, 0);
        check_eq("rst_mid_err", 32'(b.err_misalign), 0);
        check_eq("rst_mid_run", 32'({b.core_run, b.ld_ready}), 0);
        step(); step();
        rst_n = 1;

        // Reset at load pointer 10.
        for (int i = 0; i < 10; i++) begin
            b.ld_valid = 1; b.ld_data = 32'hB000_0000 + 32'(i);
            step();
        end
        b.ld_data = 32'hB000_000A;
        #1;
        check_eq("ptr10_addr", 32'(b.mem_addr), 10);
        rst_n = 0;
        #1;
        check_eq("ptr10_rst_mem", 32'({b.mem_en, b.mem_we}), 0);
        check_eq("ptr10_rst_ready", 32'({b.ld_ready, b.core_run}), 0);
        step();
        rst_n = 1;

        // Full load without ld_done: exactly 256 writes then RUN.
        wr_base = wr_cnt;
        for (int i = 0; i < 256; i++) begin
            b.ld_valid = 1; b.ld_data = 32'hC000_0000 + 32'(i);
            #1;
            check_eq("full_addr", 32'(b.mem_addr), 32'(i));
            step();
        end
        #1;
        check_eq("full_run", 32'(b.core_run), 1);
        check_eq("full_no_257", 32'({b.mem_en, b.ld_ready}), 0);
        step(); step();
        b.ld_valid = 0;
        check_eq("full_wr_count", wr_cnt - wr_base, 256);
        check_eq("full_mem0", mem_model[0], 32'hC000_0000);
        check_eq("full_mem10", mem_model[10], 32'hC000_000A);
        check_eq("full_mem255", mem_model[255], 32'hC000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
